// File: rtl/bcd_to_binary.sv
// Serial BCD-to-binary converter (reverse double-dabble): 8 BCD digits in, binary value out
// after 32 shift/correct steps, using a start/ready/done handshake.
module bcd_to_binary #(
  parameter int BIN_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       digit7,
  input  logic [3:0]       digit6,
  input  logic [3:0]       digit5,
  input  logic [3:0]       digit4,
  input  logic [3:0]       digit3,
  input  logic [3:0]       digit2,
  input  logic [3:0]       digit1,
  input  logic [3:0]       digit0,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [BIN_W-1:0] binaryValue
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [63:0] sr;
  logic [63:0] shifted;
  logic [63:0] stepped;
  logic [5:0]  cnt;
  logic        err_pend;
  logic [31:0] digits_in;
  logic        bad_digit;
  logic [BIN_W-1:0] bin_res;

  assign digits_in = {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0};

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (digits_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then pull each BCD nibble >= 8 back by 3.
  always_comb begin
    shifted = sr >> 1;
    stepped = shifted;
    for (int unsigned i = 0; i < 8; i++) begin
      if (shifted[32 + 4*i + 3]) stepped[32 + 4*i +: 4] = shifted[32 + 4*i +: 4] - 4'd3;
    end
  end

  generate
    if (BIN_W > 32) begin : g_wide
      assign bin_res = {{(BIN_W-32){1'b0}}, sr[31:0]};
    end else begin : g_narrow
      assign bin_res = sr[BIN_W-1:0];
    end
  endgenerate

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = bad_digit ? FINISH : SHIFT;
      SHIFT:   if (cnt == 6'd31) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      err_pend    <= 1'b0;
      ready       <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      binaryValue <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr       <= {digits_in, 32'd0};
            cnt      <= '0;
            err_pend <= bad_digit;
            ready    <= 1'b0;
          end
        end
        SHIFT: begin
          sr  <= stepped;
          cnt <= cnt + 6'd1;
        end
        FINISH: begin
          binaryValue <= err_pend ? '0 : bin_res;
          err         <= err_pend;
          done        <= 1'b1;
          ready       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
